// File: rtl/axi_rd_responder.sv
// AXI4 read responder over a 1-cycle-latency SRAM; one burst at a time, WRAP support under AXI_RD_RESPONDER_WRAP_EN.
// Latency: AR handshake in cycle T, sram_en in T+1, first s_rvalid in T+3; sustained 1 beat/cycle.
// Backpressure: 2-entry R buffer; reads are only issued while buffer+in-flight stays within 2 entries.
module axi_rd_responder #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_AW     = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    input  logic [ID_WIDTH-1:0]   s_arid,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic [7:0]            s_arlen,
    input  logic [2:0]            s_arsize,
    input  logic [1:0]            s_arburst,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [ID_WIDTH-1:0]   s_rid,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rlast,
    output logic                  sram_en,
    output logic [MEM_AW-1:0]     sram_addr,
    input  logic [DATA_WIDTH-1:0] sram_rdata
);

    localparam int DB = DATA_WIDTH / 8;
    localparam int LB = $clog2(DB);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    // Control state and captured burst parameters
    logic [1:0]            state;
    logic                  arready_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;      // address of the next beat to issue
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic                  err_q;
    logic [8:0]            beat_cnt;    // index of the next beat to issue, 0..len

    // One read stage between issue and buffer push
    logic                  inflight;
    logic                  inflight_last;
    logic                  inflight_err;

    // Two-entry R buffer
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [1:0]            fifo_resp [2];
    logic                  fifo_last [2];
    logic [ID_WIDTH-1:0]   fifo_id   [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            count;

    logic                  ar_fire;
    logic                  ar_err;
    logic                  pop;
    logic                  push;
    logic [2:0]            occ_after;
    logic                  issue;
    logic                  last_issue;
    logic                  head_last;

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] aligned;
    logic [ADDR_WIDTH-1:0] incr_addr;
    logic [ADDR_WIDTH-1:0] next_addr;
`ifdef AXI_RD_RESPONDER_WRAP_EN
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] wrap_addr;
`endif

    assign ar_fire   = s_arvalid & arready_q;
    assign s_arready = arready_q;

    assign s_rvalid  = (count != 2'd0);
    assign pop       = s_rvalid & s_rready;
    assign push      = inflight;
    assign head_last = fifo_last[rd_ptr];

    // Credit: entries held + read in flight - entry leaving now must stay below 2
    assign occ_after  = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue      = (state == ST_ISSUE) && (occ_after < 3'd2);
    assign last_issue = issue && (beat_cnt == {1'b0, len_q});

    // Error bursts run through the same credit pipeline but never touch the SRAM
    assign sram_en   = issue & ~err_q;
    assign sram_addr = addr_q[MEM_AW+LB-1:LB];

    // Head of the buffer drives R; fields read as zero while nothing is valid
    assign s_rdata = s_rvalid ? fifo_data[rd_ptr] : '0;
    assign s_rresp = s_rvalid ? fifo_resp[rd_ptr] : 2'b00;
    assign s_rlast = s_rvalid & head_last;
    assign s_rid   = s_rvalid ? fifo_id[rd_ptr] : '0;

    // Classify an incoming AR as an error burst
    always_comb begin
        ar_err = 1'b0;
        if (s_arsize > 3'(LB)) begin
            ar_err = 1'b1;
        end
        if (s_arburst == BURST_RSVD) begin
            ar_err = 1'b1;
        end
`ifdef AXI_RD_RESPONDER_WRAP_EN
        if ((s_arburst == BURST_WRAP) &&
            !((s_arlen == 8'd1) || (s_arlen == 8'd3) || (s_arlen == 8'd7) || (s_arlen == 8'd15))) begin
            ar_err = 1'b1;
        end
`else
        if (s_arburst == BURST_WRAP) begin
            ar_err = 1'b1;
        end
`endif
    end

    // Address of the beat after the one being issued
    always_comb begin
        step      = ADDR_WIDTH'(1) << size_q;
        aligned   = addr_q & ~(step - ADDR_WIDTH'(1));
        incr_addr = aligned + step;
`ifdef AXI_RD_RESPONDER_WRAP_EN
        wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
        wrap_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
`endif
        next_addr = incr_addr;
        if (burst_q == BURST_FIXED) begin
            next_addr = addr_q;
        end else if (burst_q == BURST_WRAP) begin
`ifdef AXI_RD_RESPONDER_WRAP_EN
            next_addr = wrap_addr;
`else
            next_addr = addr_q;
`endif
        end
    end

    // Burst FSM: accept AR, issue beats under credit, drain until rlast handshakes
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            arready_q <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= 8'd0;
            size_q    <= 3'd0;
            burst_q   <= 2'b00;
            err_q     <= 1'b0;
            beat_cnt  <= 9'd0;
        end else begin
            arready_q <= (state == ST_IDLE) && !ar_fire;
            case (state)
                ST_IDLE: begin
                    if (ar_fire) begin
                        id_q     <= s_arid;
                        addr_q   <= s_araddr;
                        len_q    <= s_arlen;
                        size_q   <= s_arsize;
                        burst_q  <= s_arburst;
                        err_q    <= ar_err;
                        beat_cnt <= 9'd0;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (issue) begin
                        addr_q   <= next_addr;
                        beat_cnt <= beat_cnt + 9'd1;
                        if (last_issue) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && head_last) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Track the single read whose data appears on sram_rdata next cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            inflight_err  <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= last_issue;
            inflight_err  <= issue & err_q;
        end
    end

    // Two-entry R buffer: push completed reads, pop on R handshake
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_resp[i] <= 2'b00;
                fifo_last[i] <= 1'b0;
                fifo_id[i]   <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= inflight_err ? '0 : sram_rdata;
                fifo_resp[wr_ptr] <= inflight_err ? RESP_SLVERR : RESP_OKAY;
                fifo_last[wr_ptr] <= inflight_last;
                fifo_id[wr_ptr]   <= id_q;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule
